hms_bcd_counter: RTL and testbench

- Timekeeping core of the hh:mm:ss clock.
- Divides the system clock to a 1 Hz tick and keeps time as six packed BCD digits.
- Feeds the 24-bit count bus consumed by the display digit multiplexer.
- Also takes the user set and clear pulses from the debounced buttons.

---
 rtl/hms_pkg.sv | 42 ++++
 rtl/bcd2_counter.sv | 55 +++++
 rtl/hms_bcd_counter.sv | 131 +++++++++++++
 tb/tb_hms_bcd_counter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hms_pkg.sv
// ============================================================================
// Module   : hms_pkg
// Purpose  : Shared digit layout, BCD limits and digit type for the hh:mm:ss
//            timekeeping core. HMS_12H_EN selects 12-hour hour limits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hms_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Bit index of the least significant bit of each digit on the count bus
    localparam int HR_T  = 20;
    localparam int HR_O  = 16;
    localparam int MIN_T = 12;
    localparam int MIN_O = 8;
    localparam int SEC_T = 4;
    localparam int SEC_O = 0;

    localparam bcd_digit_t SM_MAX_T = 4'd5;
    localparam bcd_digit_t SM_MAX_O = 4'd9;

`ifdef HMS_12H_EN
    localparam bcd_digit_t HR_MAX_T    = 4'd1;
    localparam bcd_digit_t HR_MAX_O    = 4'd2;
    localparam logic [7:0] HR_WRAP_VAL = 8'h01;
    localparam logic [7:0] HR_RST_VAL  = 8'h12;
`else
    localparam bcd_digit_t HR_MAX_T    = 4'd2;
    localparam bcd_digit_t HR_MAX_O    = 4'd3;
    localparam logic [7:0] HR_WRAP_VAL = 8'h00;
    localparam logic [7:0] HR_RST_VAL  = 8'h00;
`endif

    function automatic logic [7:0] bcd_pack(input bcd_digit_t tens, input bcd_digit_t ones);
        return {tens, ones};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd2_counter.sv
// ============================================================================
// Module   : bcd2_counter
// Purpose  : Two-digit BCD counter with wrap value, clear and carry-out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd2_counter
    import hms_pkg::*;
#(
    parameter bcd_digit_t MAX_TENS = 4'd5,
    parameter bcd_digit_t MAX_ONES = 4'd9,
    parameter logic [7:0] WRAP_VAL = 8'h00,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);

    bcd_digit_t r_tens;
    bcd_digit_t r_ones;
    logic       w_at_max;

    assign w_at_max = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);
    assign carry    = inc && !clr && w_at_max;
    assign value    = bcd_pack(r_tens, r_ones);

    // Clear wins over increment; the wrap value doubles as the cleared value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tens <= RST_VAL[7:4];
            r_ones <= RST_VAL[3:0];
        end else if (clr) begin
            r_tens <= WRAP_VAL[7:4];
            r_ones <= WRAP_VAL[3:0];
        end else if (inc) begin
            if (w_at_max) begin
                r_tens <= WRAP_VAL[7:4];
                r_ones <= WRAP_VAL[3:0];
            end else if (r_ones == 4'd9) begin
                r_ones <= 4'd0;
                r_tens <= r_tens + 4'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hms_bcd_counter.sv
// ============================================================================
// Module   : hms_bcd_counter
// Purpose  : hh:mm:ss BCD timekeeping core with 1 Hz prescaler and set/clear
//            pulses. Define HMS_12H_EN for 12-hour mode with a PM flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hms_bcd_counter #(
    parameter int CLK_HZ = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        set_hr,
    input  logic        set_min,
    input  logic        clr_sec,
    output logic [23:0] count,
    output logic        sec_tick,
    output logic        pm
);
    import hms_pkg::*;

    localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] r_presc;
    logic          r_sec_tick;
    logic          w_tick_int;
    logic          w_tick_eff;
    logic          w_sec_carry;
    logic          w_min_carry;
    logic          w_min_inc;
    logic          w_hr_inc;
    logic [7:0]    w_sec_val;
    logic [7:0]    w_min_val;
    logic [7:0]    w_hr_val;
    logic          unused_hr_carry;

    assign w_tick_int = run && (r_presc == PRESC_LAST);
    // A clear or any set pulse swallows a coincident tick entirely
    assign w_tick_eff = w_tick_int && !clr_sec && !set_hr && !set_min;
    assign w_min_inc  = set_min || w_sec_carry;
    // Seconds only carry on an effective tick, which excludes set_min
    assign w_hr_inc   = set_hr || (w_sec_carry && w_min_carry);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (clr_sec || w_tick_int) begin
            r_presc <= '0;
        end else if (run) begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec_tick <= 1'b0;
        end else begin
            r_sec_tick <= w_tick_eff;
        end
    end

    bcd2_counter #(
        .MAX_TENS (SM_MAX_T),
        .MAX_ONES (SM_MAX_O),
        .WRAP_VAL (8'h00),
        .RST_VAL  (8'h00)
    ) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_tick_eff),
        .clr   (clr_sec),
        .value (w_sec_val),
        .carry (w_sec_carry)
    );

    bcd2_counter #(
        .MAX_TENS (SM_MAX_T),
        .MAX_ONES (SM_MAX_O),
        .WRAP_VAL (8'h00),
        .RST_VAL  (8'h00)
    ) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_min_inc),
        .clr   (1'b0),
        .value (w_min_val),
        .carry (w_min_carry)
    );

    bcd2_counter #(
        .MAX_TENS (HR_MAX_T),
        .MAX_ONES (HR_MAX_O),
        .WRAP_VAL (HR_WRAP_VAL),
        .RST_VAL  (HR_RST_VAL)
    ) u_hr (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_hr_inc),
        .clr   (1'b0),
        .value (w_hr_val),
        .carry (unused_hr_carry)
    );

    assign count[HR_O  +: 8] = w_hr_val;
    assign count[MIN_O +: 8] = w_min_val;
    assign count[SEC_O +: 8] = w_sec_val;
    assign sec_tick          = r_sec_tick;

`ifdef HMS_12H_EN
    logic r_pm;

    // PM flips whenever the hour steps 11 -> 12, from either source
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pm <= 1'b0;
        end else if (w_hr_inc && (w_hr_val == 8'h11)) begin
            r_pm <= ~r_pm;
        end
    end

    assign pm = r_pm;
`else
    assign pm = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hms_bcd_counter.sv
// ============================================================================
// Module   : tb_hms_bcd_counter
// Purpose  : Directed and randomized checks of hms_bcd_counter (CLK_HZ=4)
//            against an arithmetic time model. Honours HMS_12H_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hms_bcd_counter;

    localparam int CLK_HZ = 4;
`ifdef HMS_12H_EN
    localparam logic [7:0] HR0 = 8'h12;
`else
    localparam logic [7:0] HR0 = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        set_hr = 1'b0;
    logic        set_min = 1'b0;
    logic        clr_sec = 1'b0;
    logic [23:0] count;
    logic        sec_tick;
    logic        pm;

    int errors = 0;
    int checks = 0;

    // Reference model: time as plain integers
    int m_h, m_m, m_s, m_p;
    bit m_tick, m_pm;

    hms_bcd_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .set_hr   (set_hr),
        .set_min  (set_min),
        .clr_sec  (clr_sec),
        .count    (count),
        .sec_tick (sec_tick),
        .pm       (pm)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] exp_count();
        return {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10),
                4'(m_s / 10), 4'(m_s % 10)};
    endfunction

    task automatic model_reset();
`ifdef HMS_12H_EN
        m_h = 12;
`else
        m_h = 0;
`endif
        m_m = 0; m_s = 0; m_p = 0; m_tick = 0; m_pm = 0;
    endtask

    task automatic model_hr_inc();
`ifdef HMS_12H_EN
        if (m_h == 11) m_pm = !m_pm;
        m_h = (m_h % 12) + 1;
`else
        m_h = (m_h + 1) % 24;
`endif
    endtask

    task automatic model_step();
        bit tick;
        tick = run && (m_p == CLK_HZ - 1);
        if (clr_sec || tick) m_p = 0;
        else if (run) m_p = m_p + 1;
        m_tick = tick && !clr_sec && !set_hr && !set_min;
        if (clr_sec) m_s = 0;
        if (set_min) m_m = (m_m + 1) % 60;
        if (set_hr) model_hr_inc();
        if (m_tick) begin
            m_s = m_s + 1;
            if (m_s == 60) begin
                m_s = 0;
                m_m = m_m + 1;
                if (m_m == 60) begin
                    m_m = 0;
                    model_hr_inc();
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b1;
        run = 1'b0; set_hr = 1'b0; set_min = 1'b0; clr_sec = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulse_hr(input int n);
        for (int i = 0; i < n; i++) begin
            set_hr = 1'b1; tick(); set_hr = 1'b0;
        end
    endtask

    task automatic pulse_min(input int n);
        for (int i = 0; i < n; i++) begin
            set_min = 1'b1; tick(); set_min = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        run = 1'b1;
        repeat (8) tick();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (count !== {HR0, 16'h0000} || sec_tick !== 1'b0 || pm !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: count=%h sec_tick=%b pm=%b, expected %h 0 0", count, sec_tick, pm, {HR0, 16'h0000});
        end
        @(posedge clk); #1;
        checks++;
        if (count !== {HR0, 16'h0000} || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: count=%h sec_tick=%b, expected %h 0", count, sec_tick, {HR0, 16'h0000});
        end
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (count !== {HR0, 16'h0000} || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL pre_first_tick: count=%h sec_tick=%b, expected %h 0", count, sec_tick, {HR0, 16'h0000});
        end
        tick();
        checks++;
        if (count !== {HR0, 16'h0001} || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL first_tick: count=%h sec_tick=%b, expected %h 1", count, sec_tick, {HR0, 16'h0001});
        end
        tick();
        checks++;
        if (sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_width: sec_tick=%b, expected 0", sec_tick);
        end
        repeat (35) tick();
        checks++;
        if (count !== {HR0, 16'h0010} || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL ten_seconds: count=%h sec_tick=%b, expected %h 1", count, sec_tick, {HR0, 16'h0010});
        end
    endtask

`ifndef HMS_12H_EN
    task automatic test_carry_chain();
        apply_reset();
        pulse_hr(23);
        pulse_min(59);
        run = 1'b1;
        repeat (59 * CLK_HZ) tick();
        checks++;
        if (count !== 24'h235959) begin
            errors++;
            $display("FAIL carry_pre: count=%h, expected 235959", count);
        end
        repeat (CLK_HZ) tick();
        checks++;
        if (count !== 24'h000000 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL carry_wrap: count=%h sec_tick=%b, expected 000000 1", count, sec_tick);
        end
    endtask

    task automatic test_set_wrap();
        apply_reset();
        pulse_min(59);
        run = 1'b1;
        repeat (30 * CLK_HZ) tick();
        run = 1'b0;
        checks++;
        if (count !== 24'h005930) begin
            errors++;
            $display("FAIL set_min_pre: count=%h, expected 005930", count);
        end
        pulse_min(1);
        checks++;
        if (count !== 24'h000030) begin
            errors++;
            $display("FAIL set_min_wrap: count=%h, expected 000030", count);
        end
        apply_reset();
        pulse_hr(23);
        checks++;
        if (count !== 24'h230000) begin
            errors++;
            $display("FAIL set_hr_pre: count=%h, expected 230000", count);
        end
        pulse_hr(1);
        checks++;
        if (count !== 24'h000000) begin
            errors++;
            $display("FAIL set_hr_wrap: count=%h, expected 000000", count);
        end
    endtask
`endif

    task automatic test_simultaneous();
        apply_reset();
        run = 1'b1;
        repeat (12 * CLK_HZ + CLK_HZ - 1) tick();
        clr_sec = 1'b1; tick(); clr_sec = 1'b0;
        checks++;
        if (count !== {HR0, 16'h0000} || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL clr_on_tick: count=%h sec_tick=%b, expected %h 0", count, sec_tick, {HR0, 16'h0000});
        end
        repeat (CLK_HZ - 1) tick();
        checks++;
        if (count !== {HR0, 16'h0000} || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL clr_early_tick: count=%h sec_tick=%b, expected %h 0", count, sec_tick, {HR0, 16'h0000});
        end
        tick();
        checks++;
        if (count !== {HR0, 16'h0001} || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL clr_next_tick: count=%h sec_tick=%b, expected %h 1", count, sec_tick, {HR0, 16'h0001});
        end
        apply_reset();
        run = 1'b1;
        repeat (5 * CLK_HZ + CLK_HZ - 1) tick();
        set_min = 1'b1; tick(); set_min = 1'b0;
        checks++;
        if (count !== {HR0, 16'h0105} || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL set_on_tick: count=%h sec_tick=%b, expected %h 0", count, sec_tick, {HR0, 16'h0105});
        end
        repeat (CLK_HZ) tick();
        checks++;
        if (count !== {HR0, 16'h0106} || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL set_next_tick: count=%h sec_tick=%b, expected %h 1", count, sec_tick, {HR0, 16'h0106});
        end
    endtask

    task automatic test_hold();
        apply_reset();
        run = 1'b1;
        repeat (3 * CLK_HZ + 2) tick();
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (count !== {HR0, 16'h0003} || sec_tick !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: count=%h sec_tick=%b, expected %h 0", i, count, sec_tick, {HR0, 16'h0003});
            end
        end
        run = 1'b1;
        tick();
        checks++;
        if (count !== {HR0, 16'h0003} || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL resume_early: count=%h sec_tick=%b, expected %h 0", count, sec_tick, {HR0, 16'h0003});
        end
        tick();
        checks++;
        if (count !== {HR0, 16'h0004} || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL resume_tick: count=%h sec_tick=%b, expected %h 1", count, sec_tick, {HR0, 16'h0004});
        end
    endtask

`ifdef HMS_12H_EN
    task automatic test_12h();
        apply_reset();
        checks++;
        if (count !== 24'h120000 || pm !== 1'b0) begin
            errors++;
            $display("FAIL h12_reset: count=%h pm=%b, expected 120000 0", count, pm);
        end
        pulse_hr(11);
        pulse_min(59);
        run = 1'b1;
        repeat (59 * CLK_HZ) tick();
        checks++;
        if (count !== 24'h115959 || pm !== 1'b0) begin
            errors++;
            $display("FAIL h12_pre_noon: count=%h pm=%b, expected 115959 0", count, pm);
        end
        repeat (CLK_HZ) tick();
        checks++;
        if (count !== 24'h120000 || pm !== 1'b1) begin
            errors++;
            $display("FAIL h12_noon: count=%h pm=%b, expected 120000 1", count, pm);
        end
        run = 1'b0;
        pulse_min(59);
        run = 1'b1;
        repeat (59 * CLK_HZ) tick();
        repeat (CLK_HZ) tick();
        checks++;
        if (count !== 24'h010000 || pm !== 1'b1) begin
            errors++;
            $display("FAIL h12_one: count=%h pm=%b, expected 010000 1", count, pm);
        end
    endtask
`endif

    task automatic test_random();
        int r;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 15));
            run     = ($urandom_range(0, 7) != 0);
            clr_sec = (r == 0);
            set_hr  = (r == 1) || (r == 3);
            set_min = (r == 2) || (r == 3);
            tick();
            checks++;
            if (count !== exp_count() || sec_tick !== m_tick || pm !== m_pm) begin
                errors++;
                $display("FAIL random_cycle%0d: count=%h sec_tick=%b pm=%b, expected %h %b %b",
                         i, count, sec_tick, pm, exp_count(), m_tick, m_pm);
            end
        end
        run = 1'b0; clr_sec = 1'b0; set_hr = 1'b0; set_min = 1'b0;
    endtask

    initial begin
        test_reset();
`ifndef HMS_12H_EN
        test_carry_chain();
        test_set_wrap();
`endif
        test_simultaneous();
        test_hold();
`ifdef HMS_12H_EN
        test_12h();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
